fetch_exec_sequencer: RTL
=========================

// Module: fetch_exec_sequencer
// PURPOSE
//   Multi-cycle instruction sequencer for the 4-bit core. Owns the PC and
//   the instruction register (IR), fetches from instruction ROM over a
//   req/ack handshake, decodes, and drives one-cycle datapath strobes
//   (ALU op, accumulator load, register-file write, immediate select).
//   Supports JMP/JZ/HLT, run/halt control and a fetch timeout.
// PARAMETERS
//   ADDR_W   4   PC / ROM address width; PC wraps modulo 2**ADDR_W
//   INSTR_W  8   instruction width; [7:4]=opcode, [3:0]=operand
//   TIMEOUT  15  max FETCH cycles awaiting mem_ack before bus error (>=1)
// PORTS
//   clk        in   1        clock, rising edge
//   reset      in   1        synchronous, active-high
//   run        in   1        start/resume request, sampled only in HALT
//   zero_flag  in   1        accumulator-zero flag from datapath
//   mem_req    out  1        ROM read request
//   mem_addr   out  ADDR_W   ROM address (= PC)
//   mem_ack    in   1        ROM data valid; meaningful only while mem_req=1
//   mem_rdata  in   INSTR_W  ROM instruction data
//   alu_op     out  3        ALU operation select
//   acc_load   out  1        accumulator load strobe
//   rf_write   out  1        register-file write strobe
//   imm        out  1        immediate-operand select
//   imm_val    out  4        operand field, = IR[3:0] continuously
//   halted     out  1        high while in HALT
//   bus_err    out  1        fetch timeout occurred
// BEHAVIOUR
//   States: HALT, FETCH, DECODE, EXECUTE.
//   Reset (sync): state=HALT, PC=0, IR=0, wait_cnt=0, bus_err=0; all strobes,
//     mem_req, alu_op = 0; halted=1.
//   HALT: halted=1. run=1 -> FETCH next cycle, bus_err cleared on exit.
//   FETCH: mem_req=1, mem_addr=PC. wait_cnt=0 on entry.
//     - mem_ack=1: IR<=mem_rdata, -> DECODE.
//     - mem_ack=0, wait_cnt==TIMEOUT-1: bus_err<=1, -> HALT, PC unchanged.
//     - else wait_cnt++ (ack on the TIMEOUT-th FETCH cycle is still taken).
//     mem_ack while mem_req=0 is ignored.
//   DECODE: one cycle, no strobes, mem_req=0; -> EXECUTE.
//   EXECUTE: one cycle; strobes valid this cycle only; -> FETCH unless HLT.
//     0x0 ADD alu_op=000 acc_load
//     0x1 SUB alu_op=001 acc_load
//     0x2 AND alu_op=010 acc_load
//     0x3 OR  alu_op=011 acc_load
//     0x4 MOV alu_op=101 imm rf_write acc_load
//     0x8 JMP PC<=operand[ADDR_W-1:0] (zero-extended if ADDR_W>4)
//     0x9 JZ  zero_flag=1: as JMP; else PC+1
//     0xF HLT PC<=PC+1, -> HALT
//     other: NOP, alu_op=000, no strobes
//   PC: +1 at end of EXECUTE unless jump taken; all-ones wraps to 0.
//   Min instruction latency 3 cycles (ack in first FETCH cycle).
//   Outside EXECUTE: acc_load=rf_write=imm=0, alu_op=000.
//   run ignored outside HALT. reset mid-fetch drops mem_req next cycle and
//   discards any in-flight ack.
// TESTING
//   1. Reset, run=1, ROM[0]=0x05 ADD, ack same cycle -> mem_req@c1, DECODE@c2,
//      acc_load=1 alu_op=000 @c3 only, mem_addr=1 @c4.
//   2. ROM[1]=0x47 MOV -> EXECUTE: alu_op=101 imm=1 rf_write=1 acc_load=1,
//      imm_val=7.
//   3. JZ 0x9C with zero_flag=0 -> next fetch addr PC+1; zero_flag=1 -> addr 0xC.
//   4. mem_ack held 0 -> after 15 FETCH cycles halted=1 bus_err=1, PC unchanged;
//      ack on 15th cycle instead -> normal DECODE, bus_err=0.
//   5. PC=0xF executing ADD -> next mem_addr=0x0; HLT at 0x3 -> halted=1,
//      run -> fetch from 0x4.
//   6. reset asserted during FETCH wait -> next cycle HALT, PC=0, mem_req=0.

Source files
------------

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit core.
// Owns PC and IR, fetches over a req/ack ROM handshake and issues one-cycle datapath strobes.
module fetch_exec_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               run_i,
    input  logic               zero_flag_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [INSTR_W-1:0] mem_rdata_i,
    output logic [2:0]         alu_op_o,
    output logic               acc_load_o,
    output logic               rf_write_o,
    output logic               imm_o,
    output logic [3:0]         imm_val_o,
    output logic               halted_o,
    output logic               bus_err_o
);
    // state   | meaning
    // HALT    | idle, waiting for run_i
    // FETCH   | mem_req high, waiting for mem_ack or timeout
    // DECODE  | IR loaded, strobes prepared for the next cycle
    // EXECUTE | strobes active for one cycle, PC updated at the end
    typedef enum logic [1:0] {
        STATE_HALT    = 2'd0,
        STATE_FETCH   = 2'd1,
        STATE_DECODE  = 2'd2,
        STATE_EXECUTE = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT - 1);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_MOV = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               bus_err_q;
    logic               mem_req_q;
    logic               halted_q;
    logic [2:0]         alu_op_q;
    logic               acc_load_q;
    logic               rf_write_q;
    logic               imm_q;

    logic [3:0]         opcode;
    logic [2:0]         alu_op_d;
    logic               acc_load_d;
    logic               rf_write_d;
    logic               imm_d;
    logic [ADDR_W-1:0]  pc_next_d;

    assign opcode = ir_q[7:4];

    always_comb begin
        alu_op_d   = 3'b000;
        acc_load_d = 1'b0;
        rf_write_d = 1'b0;
        imm_d      = 1'b0;
        case (opcode)
            OP_ADD: begin alu_op_d = 3'b000; acc_load_d = 1'b1; end
            OP_SUB: begin alu_op_d = 3'b001; acc_load_d = 1'b1; end
            OP_AND: begin alu_op_d = 3'b010; acc_load_d = 1'b1; end
            OP_OR:  begin alu_op_d = 3'b011; acc_load_d = 1'b1; end
            OP_MOV: begin
                alu_op_d   = 3'b101;
                acc_load_d = 1'b1;
                rf_write_d = 1'b1;
                imm_d      = 1'b1;
            end
            default: ;
        endcase
    end

    // Jump target is the operand field, resized to the PC width.
    always_comb begin
        pc_next_d = pc_q + ADDR_W'(1);
        if (opcode == OP_JMP || (opcode == OP_JZ && zero_flag_i)) begin
            pc_next_d = ADDR_W'(ir_q[3:0]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= STATE_HALT;
            pc_q       <= '0;
            ir_q       <= '0;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            halted_q   <= 1'b1;
            alu_op_q   <= 3'b000;
            acc_load_q <= 1'b0;
            rf_write_q <= 1'b0;
            imm_q      <= 1'b0;
        end else begin
            alu_op_q   <= 3'b000;
            acc_load_q <= 1'b0;
            rf_write_q <= 1'b0;
            imm_q      <= 1'b0;
            case (state_q)
                STATE_HALT: begin
                    if (run_i) begin
                        state_q    <= STATE_FETCH;
                        mem_req_q  <= 1'b1;
                        halted_q   <= 1'b0;
                        bus_err_q  <= 1'b0;
                        wait_cnt_q <= WAIT_LOAD;
                    end
                end
                STATE_FETCH: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (mem_ack_i) begin
                        ir_q      <= mem_rdata_i;
                        state_q   <= STATE_DECODE;
                        mem_req_q <= 1'b0;
                    end else if (wait_cnt_q == '0) begin
                        bus_err_q <= 1'b1;
                        state_q   <= STATE_HALT;
                        mem_req_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                end
                STATE_DECODE: begin
                    state_q    <= STATE_EXECUTE;
                    alu_op_q   <= alu_op_d;
                    acc_load_q <= acc_load_d;
                    rf_write_q <= rf_write_d;
                    imm_q      <= imm_d;
                end
                STATE_EXECUTE: begin
                    pc_q <= pc_next_d;
                    if (opcode == OP_HLT) begin
                        state_q  <= STATE_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q    <= STATE_FETCH;
                        mem_req_q  <= 1'b1;
                        wait_cnt_q <= WAIT_LOAD;
                    end
                end
                default: state_q <= STATE_HALT;
            endcase
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = pc_q;
    assign alu_op_o   = alu_op_q;
    assign acc_load_o = acc_load_q;
    assign rf_write_o = rf_write_q;
    assign imm_o      = imm_q;
    assign imm_val_o  = ir_q[3:0];
    assign halted_o   = halted_q;
    assign bus_err_o  = bus_err_q;

endmodule
